// File: rtl/img_pkg.sv
// Shared types and constants for the 8x8 image-operation sequencer.
package img_pkg;

  localparam int N_PIX      = 64;
  localparam int N_OP       = 15;
  localparam int N_OUT      = 16;
  localparam int OPW        = 4;
  localparam int N_VALID_OP = 8;

  typedef enum logic [OPW-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_SHL = 4'd3,
    OP_SHR = 4'd4,
    OP_MAX = 4'd5,
    OP_MIN = 4'd6,
    OP_ABS = 4'd7,
    OP_NOP = 4'd8
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_OUT
  } state_e;

endpackage

// File: rtl/img_op_scheduler_op_buf.sv
// Opcode register file: one write port (load side), one read port (issue side).
module op_buf #(
  parameter int DEPTH = 15,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         we,
  input  logic [3:0]   waddr,
  input  logic [W-1:0] wdata,
  input  logic [3:0]   raddr,
  output logic [W-1:0] rdata
);

  logic [W-1:0] mem [DEPTH];

  // Contents survive reset so a re-run can reuse them.
  always_ff @(posedge clk) begin
    if (we && int'(waddr) < DEPTH) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = (int'(raddr) < DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/img_op_scheduler.sv
// Burst capture, op issue over start/done, and result-window streaming.
module img_op_scheduler
  import img_pkg::*;
#(
  parameter int N_PIX   = 64,
  parameter int N_OP    = 15,
  parameter int N_OUT   = 16,
  parameter int OPW     = 4,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [OPW-1:0] op,
  output logic           ld_en,
  output logic [5:0]     ld_addr,
  output logic           dp_start,
  output logic [OPW-1:0] dp_op,
  input  logic           dp_done,
  output logic [3:0]     rd_addr,
  output logic           out_valid,
  output logic           busy,
  output logic           proto_err
);

  localparam int TW = $clog2(TIMEOUT);

  state_e         state_q, state_d;
  logic [5:0]     pix_q, pix_d;
  logic [3:0]     idx_q, idx_d;
  logic [3:0]     out_d;
  logic [TW-1:0]  to_q, to_d;
  logic           start_d, ov_d, perr_d, busy_d;
  logic           iv_q, iv_rise;
  logic [OPW-1:0] dpop_d, rd_op;
  logic           ob_we;
  logic [3:0]     ob_waddr;

  assign iv_rise = in_valid & ~iv_q;

  op_buf #(
    .DEPTH(N_OP),
    .W    (OPW)
  ) u_op_buf (
    .clk  (clk),
    .we   (ob_we),
    .waddr(ob_waddr),
    .wdata(op),
    .raddr(idx_q),
    .rdata(rd_op)
  );

  always_comb begin
    state_d  = state_q;
    pix_d    = pix_q;
    idx_d    = idx_q;
    to_d     = to_q;
    out_d    = rd_addr;
    start_d  = 1'b0;
    dpop_d   = dp_op;
    ov_d     = 1'b0;
    perr_d   = 1'b0;
    ld_en    = 1'b0;
    ld_addr  = '0;
    ob_we    = 1'b0;
    ob_waddr = pix_q[3:0];
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          ld_en    = ~rst;
          ob_we    = 1'b1;
          ob_waddr = '0;
          pix_d    = 6'd1;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        ld_addr = pix_q;
        if (!in_valid) begin
          perr_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          ld_en = ~rst;
          ob_we = (pix_q < 6'(N_OP));
          if (pix_q == 6'(N_PIX - 1)) begin
            idx_d   = '0;
            state_d = S_ISSUE;
          end else begin
            pix_d = pix_q + 6'd1;
          end
        end
      end
      S_ISSUE: begin
        perr_d = iv_rise;
        if (idx_q == 4'(N_OP)) begin
          out_d   = '0;
          ov_d    = 1'b1;
          state_d = S_OUT;
        end else if (rd_op >= OPW'(N_VALID_OP)) begin
          idx_d = idx_q + 4'd1;
        end else begin
          start_d = 1'b1;
          dpop_d  = rd_op;
          to_d    = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        perr_d = iv_rise;
        // A done coinciding with the last timeout cycle wins.
        if (dp_done) begin
          idx_d   = idx_q + 4'd1;
          state_d = S_ISSUE;
        end else if (to_q == TW'(TIMEOUT - 1)) begin
          perr_d  = 1'b1;
          idx_d   = idx_q + 4'd1;
          state_d = S_ISSUE;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      S_OUT: begin
        perr_d = iv_rise;
        if (rd_addr == 4'(N_OUT - 1)) begin
          state_d = S_IDLE;
        end else begin
          out_d = rd_addr + 4'd1;
          ov_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pix_q     <= '0;
      idx_q     <= '0;
      to_q      <= '0;
      rd_addr   <= '0;
      dp_start  <= 1'b0;
      dp_op     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      proto_err <= 1'b0;
      iv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pix_q     <= pix_d;
      idx_q     <= idx_d;
      to_q      <= to_d;
      rd_addr   <= out_d;
      dp_start  <= start_d;
      dp_op     <= dpop_d;
      out_valid <= ov_d;
      busy      <= busy_d;
      proto_err <= perr_d;
      iv_q      <= in_valid;
    end
  end

endmodule
